// File: rtl/adc_push_rcvr_if.sv
// Interface bundling the ADC push handshake, error control and the
// valid/ready output stream of adc_push_rcvr.
//   oen_b[5:0]   ADC output enables, active low
//   lpush_b      push strobe, active low
//   end_tgl      end-of-frame toggle
//   adc_data     shared 12-bit ADC bus
//   clr_err      clear of the sticky error flags
//   dout[17:0]   output word, [17:16] = type
//   dvalid       dout is valid
//   dready       downstream accepts dout
//   frame_cnt    closed-frame counter
//   ovfl, perr   sticky overflow / protocol-error flags
interface adc_push_rcvr_if;
  logic [5:0]  oen_b;
  logic        lpush_b;
  logic        end_tgl;
  logic [11:0] adc_data;
  logic        clr_err;
  logic [17:0] dout;
  logic        dvalid;
  logic        dready;
  logic [7:0]  frame_cnt;
  logic        ovfl;
  logic        perr;

  // Master: block controller / ADCs plus downstream consumer
  modport master (
    output oen_b, lpush_b, end_tgl, adc_data, clr_err, dready,
    input  dout, dvalid, frame_cnt, ovfl, perr
  );

  // Slave: the receiver
  modport slave (
    input  oen_b, lpush_b, end_tgl, adc_data, clr_err, dready,
    output dout, dvalid, frame_cnt, ovfl, perr
  );
endinterface

// File: rtl/adc_push_rcvr.sv
// CFEB ADC readout receiver. Registers the ADC handshake pins, captures words
// tagged with their ADC index into a FWFT FIFO, closes frames on END toggles
// with a word-count and checksum trailer, and streams the FIFO out via
// valid/ready.
//   i_clk    system clock
//   i_rst_b  asynchronous reset, active low
//   io_bus   adc_push_rcvr_if.slave (handshake inputs, output stream, flags)
module adc_push_rcvr #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WCNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  adc_push_rcvr_if.slave   io_bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 18;

  typedef enum logic [1:0] {IDLE, COLLECT, TRL_CNT, TRL_CHK} state_t;

  // Input stage: every pin registered once
  logic [5:0]  r_oen_b;
  logic        r_lpush_b;
  logic        r_end;
  logic        r_end_d;
  logic [11:0] r_adc;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_oen_b   <= 6'h3f;
      r_lpush_b <= 1'b1;
      r_end     <= 1'b0;
      r_end_d   <= 1'b0;
      r_adc     <= 12'd0;
    end else begin
      r_oen_b   <= io_bus.oen_b;
      r_lpush_b <= io_bus.lpush_b;
      r_end     <= io_bus.end_tgl;
      r_end_d   <= r_end;
      r_adc     <= io_bus.adc_data;
    end
  end

  // Push decode
  logic       w_push;
  logic       w_onehot;
  logic       w_capture;
  logic       w_end_edge;
  logic [2:0] w_idx;

  assign w_push     = ~r_lpush_b;
  assign w_onehot   = $onehot(~r_oen_b);
  assign w_capture  = w_push & w_onehot;
  assign w_end_edge = r_end ^ r_end_d;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!r_oen_b[i]) w_idx = 3'(i);
    end
  end

  // FIFO state
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_dout;
  logic          r_dvalid;

  logic          w_pop;
  logic          w_fifo_free;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_cnt_after_pop;

  assign w_pop           = r_dvalid & io_bus.dready;
  assign w_fifo_free     = (r_count != CW'(DEPTH)) | w_pop;
  assign w_rd_ptr_nxt    = r_rd_ptr + AW'(w_pop);
  assign w_cnt_after_pop = r_count - CW'(w_pop);

  // Frame state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_cnt;
  logic [11:0]       r_chk;
  logic [7:0]        r_frame_cnt;
  logic              r_ovfl;
  logic              r_perr;

  logic          w_wr_en;
  logic [DW-1:0] w_wr_data;
  logic          w_data_acc;
  logic          w_ovfl_set;
  logic          w_perr_set;
  logic          w_frame_done;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and FIFO write source selection
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_data    = '0;
    w_data_acc   = 1'b0;
    w_ovfl_set   = 1'b0;
    w_perr_set   = w_push & ~w_onehot;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_capture) begin
          if (w_fifo_free) begin
            w_wr_en    = 1'b1;
            w_wr_data  = {2'b00, 1'b0, w_idx, r_adc};
            w_data_acc = 1'b1;
          end else begin
            w_ovfl_set = 1'b1;
          end
          w_state_nxt = COLLECT;
        end
        // A word captured together with the END edge is written this cycle,
        // so it lands ahead of the count trailer.
        if (w_end_edge) w_state_nxt = TRL_CNT;
      end
      TRL_CNT: begin
        if (w_capture) w_perr_set = 1'b1;
        if (w_fifo_free) begin
          w_wr_en     = 1'b1;
          w_wr_data   = {2'b01, 16'(r_cnt)};
          w_state_nxt = TRL_CHK;
        end
      end
      TRL_CHK: begin
        if (w_capture) w_perr_set = 1'b1;
        if (w_fifo_free) begin
          w_wr_en      = 1'b1;
          w_wr_data    = {2'b10, 4'b0, r_chk};
          w_frame_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-frame count/checksum, frame counter and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_cnt       <= '0;
      r_chk       <= 12'd0;
      r_frame_cnt <= 8'd0;
      r_ovfl      <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      if (w_frame_done) begin
        r_cnt       <= '0;
        r_chk       <= 12'd0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (w_data_acc) begin
        if (r_cnt != '1) r_cnt <= r_cnt + WCNT_W'(1);
        r_chk <= r_chk ^ r_adc;
      end
      r_ovfl <= w_ovfl_set | (r_ovfl & ~io_bus.clr_err);
      r_perr <= w_perr_set | (r_perr & ~io_bus.clr_err);
    end
  end

  // FIFO storage (no reset needed on the array)
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // FIFO pointers and output register; dout mirrors the head entry, so it
  // reflects a write one cycle later and holds while stalled.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_after_pop + CW'(w_wr_en);
      r_dvalid <= (w_cnt_after_pop != '0);
      if (w_cnt_after_pop != '0) r_dout <= r_mem[w_rd_ptr_nxt];
    end
  end

  assign io_bus.dout      = r_dout;
  assign io_bus.dvalid    = r_dvalid;
  assign io_bus.frame_cnt = r_frame_cnt;
  assign io_bus.ovfl      = r_ovfl;
  assign io_bus.perr      = r_perr;
endmodule
